// File: rtl/counters_pkg.sv
// Shared command encoding for the counter command arbiter.
package counters_pkg;

  localparam int unsigned CMD_W = 2;

  typedef logic [CMD_W-1:0] cmd_t;

  localparam cmd_t CMD_CLR  = 2'b00;
  localparam cmd_t CMD_INC  = 2'b01;
  localparam cmd_t CMD_DEC  = 2'b10;
  localparam cmd_t CMD_LOAD = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester after last_granted.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  input  logic [IDX_W-1:0] last_granted,
  output logic [NREQ-1:0]  grant,
  output logic             valid
);

  logic [NREQ-1:0]  eligible;
  logic [IDX_W-1:0] idx;

  // Rotating priority search starting one past the previous winner
  always_comb begin
    grant    = '0;
    valid    = 1'b0;
    idx      = '0;
    eligible = req & ~mask;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDX_W'((32'(last_granted) + i + 32'd1) % NREQ);
      if (!valid && eligible[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_cmd_arbiter.sv
// Shared counter with round-robin command arbitration and prescaled auto-increment.
module counter_cmd_arbiter
  import counters_pkg::*;
#(
  parameter int unsigned       NREQ     = 4,
  parameter int unsigned       WIDTH    = 8,
  parameter int unsigned       DIV_W    = 24,
  parameter logic [DIV_W-1:0]  DIV_LOAD = DIV_W'(24'h100000)
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       cmd,
  input  logic [WIDTH*NREQ-1:0]   load_val,
  input  logic                    autocount_en,
  input  logic                    pause,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        count,
  output logic                    zero_pulse,
  output logic                    wrap_pulse,
  output logic                    overrun_pulse
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [DIV_W-1:0] div_q;
  logic [IDX_W-1:0] last_q;
  logic             tick_pend_q;

  logic [NREQ-1:0]  arb_grant_c;
  logic             arb_valid_c;

  logic             tick_c;
  logic             ext_go_c;
  logic             serve_tick_c;
  logic             upd_c;
  cmd_t             sel_cmd_c;
  cmd_t             op_c;
  logic [WIDTH-1:0] sel_val_c;
  logic [IDX_W-1:0] sel_idx_c;

  logic [DIV_W-1:0] div_d;
  logic [IDX_W-1:0] last_d;
  logic             tick_pend_d;
  logic [NREQ-1:0]  gnt_d;
  logic [WIDTH-1:0] count_d;
  logic             zero_d;
  logic             wrap_d;
  logic             overrun_d;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req          (req),
    .mask         (gnt),
    .last_granted (last_q),
    .grant        (arb_grant_c),
    .valid        (arb_valid_c)
  );

  // Next-state: prescaler, winner selection, counter update, pulses, tick bookkeeping
  always_comb begin
    tick_c       = 1'b0;
    div_d        = div_q;
    sel_cmd_c    = CMD_INC;
    sel_val_c    = '0;
    sel_idx_c    = last_q;
    op_c         = CMD_INC;
    count_d      = count;
    wrap_d       = 1'b0;
    zero_d       = 1'b0;
    gnt_d        = '0;
    last_d       = last_q;
    tick_pend_d  = tick_pend_q;
    overrun_d    = 1'b0;
    ext_go_c     = 1'b0;
    serve_tick_c = 1'b0;
    upd_c        = 1'b0;

    // prescaler free-runs, independent of pause and autocount_en
    tick_c = (div_q == '0);
    div_d  = tick_c ? DIV_LOAD : div_q - DIV_W'(1);

    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_grant_c[i]) begin
        sel_cmd_c = cmd_t'(cmd[2*i +: 2]);
        sel_val_c = load_val[WIDTH*i +: WIDTH];
        sel_idx_c = IDX_W'(i);
      end
    end

    // external winners always beat the pending tick; pause blocks both
    ext_go_c     = arb_valid_c & ~pause;
    serve_tick_c = tick_pend_q & autocount_en & ~arb_valid_c & ~pause;
    upd_c        = ext_go_c | serve_tick_c;
    op_c         = ext_go_c ? sel_cmd_c : CMD_INC;

    if (upd_c) begin
      case (op_c)
        CMD_CLR:  count_d = '0;
        CMD_INC:  begin
          count_d = count + WIDTH'(1);
          wrap_d  = (count == '1);
        end
        CMD_DEC:  begin
          count_d = count - WIDTH'(1);
          wrap_d  = (count == '0);
        end
        default:  count_d = sel_val_c;
      endcase
    end
    zero_d = upd_c & (count != '0) & (count_d == '0);

    gnt_d  = ext_go_c ? arb_grant_c : '0;
    last_d = ext_go_c ? sel_idx_c : last_q;

    // a tick landing on an already pending tick is lost
    overrun_d = tick_c & autocount_en & tick_pend_q;
    if (!autocount_en) begin
      tick_pend_d = 1'b0;
    end else if (serve_tick_c) begin
      tick_pend_d = 1'b0;
    end else if (tick_c) begin
      tick_pend_d = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      div_q         <= DIV_LOAD;
      last_q        <= IDX_W'(NREQ - 1);
      tick_pend_q   <= 1'b0;
      gnt           <= '0;
      count         <= '0;
      zero_pulse    <= 1'b0;
      wrap_pulse    <= 1'b0;
      overrun_pulse <= 1'b0;
    end else begin
      div_q         <= div_d;
      last_q        <= last_d;
      tick_pend_q   <= tick_pend_d;
      gnt           <= gnt_d;
      count         <= count_d;
      zero_pulse    <= zero_d;
      wrap_pulse    <= wrap_d;
      overrun_pulse <= overrun_d;
    end
  end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Randomized bench for counter_cmd_arbiter against a behavioural reference model.
module tb_counter_cmd_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DIV_W = 24;
  localparam int DL    = 3;
  localparam int MOD   = 1 << WIDTH;

  logic                  sys_clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     cmd;
  logic [WIDTH*NREQ-1:0] load_val;
  logic                  autocount_en;
  logic                  pause;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      count;
  logic                  zero_pulse;
  logic                  wrap_pulse;
  logic                  overrun_pulse;

  int total = 0;
  int bad   = 0;

  // reference model state
  int              m_count = 0;
  int              m_last  = NREQ - 1;
  int              m_k     = 0;
  bit              m_pend  = 1'b0;
  logic [NREQ-1:0] m_gnt   = '0;
  bit              m_zero  = 1'b0;
  bit              m_wrap  = 1'b0;
  bit              m_ovr   = 1'b0;
  bit              m_valid = 1'b0;

  counter_cmd_arbiter #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .DIV_W    (DIV_W),
    .DIV_LOAD (24'd3)
  ) dut (
    .sys_clk       (sys_clk),
    .reset_n       (reset_n),
    .req           (req),
    .cmd           (cmd),
    .load_val      (load_val),
    .autocount_en  (autocount_en),
    .pause         (pause),
    .gnt           (gnt),
    .count         (count),
    .zero_pulse    (zero_pulse),
    .wrap_pulse    (wrap_pulse),
    .overrun_pulse (overrun_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs held during the cycle
  task automatic model_step();
    int  win;
    int  op;
    int  val;
    int  nc;
    bit  tick;
    bit  serve;
    win   = -1;
    op    = -1;
    val   = 0;
    nc    = m_count;
    serve = 1'b0;
    if (!reset_n) begin
      m_count = 0;
      m_last  = NREQ - 1;
      m_k     = 0;
      m_pend  = 1'b0;
      m_gnt   = '0;
      m_zero  = 1'b0;
      m_wrap  = 1'b0;
      m_ovr   = 1'b0;
      m_valid = 1'b1;
    end else begin
      tick = ((m_k % (DL + 1)) == DL);
      m_k++;
      for (int off = 1; off <= NREQ; off++) begin
        int j;
        j = (m_last + off) % NREQ;
        if (win < 0 && req[j] && !m_gnt[j]) win = j;
      end
      m_ovr  = tick && autocount_en && m_pend;
      m_zero = 1'b0;
      m_wrap = 1'b0;
      m_gnt  = '0;
      if (!pause && win >= 0) begin
        m_gnt[win] = 1'b1;
        m_last     = win;
        op         = int'(cmd[2*win +: 2]);
        val        = int'(load_val[WIDTH*win +: WIDTH]);
      end else if (!pause && autocount_en && m_pend) begin
        op    = 1;
        serve = 1'b1;
      end
      if (!autocount_en || serve) m_pend = 1'b0;
      else if (tick) m_pend = 1'b1;
      if (op >= 0) begin
        case (op)
          0: nc = 0;
          1: begin nc = (m_count + 1) % MOD; m_wrap = (m_count == MOD - 1); end
          2: begin nc = (m_count + MOD - 1) % MOD; m_wrap = (m_count == 0); end
          default: nc = val;
        endcase
        m_zero  = (m_count != 0) && (nc == 0);
        m_count = nc;
      end
    end
  endtask

  task automatic compare();
    if (m_valid) begin
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("count", 32'(count), 32'(m_count));
      chk("zero_pulse", 32'(zero_pulse), 32'(m_zero));
      chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
      chk("overrun_pulse", 32'(overrun_pulse), 32'(m_ovr));
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    compare();
  endtask

  task automatic set_req(input int i, input int c, input int v);
    req[i]                   = 1'b1;
    cmd[2*i +: 2]            = 2'(c);
    load_val[WIDTH*i +: WIDTH] = WIDTH'(v);
  endtask

  // Present one command and wait (bounded) until its grant is visible
  task automatic issue(input int i, input int c, input int v);
    set_req(i, c, v);
    for (int n = 0; n < 8; n++) begin
      cyc();
      if (gnt[i]) break;
    end
    chk("issue_gnt", 32'(gnt[i]), 32'd1);
    req[i] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    req     = '0;
    repeat (n) cyc();
    reset_n = 1'b1;
  endtask

  task automatic rand_cmd(input int i);
    int c;
    int r;
    int v;
    c = int'($urandom_range(0, 3));
    r = int'($urandom_range(0, 3));
    case (r)
      0:       v = 0;
      1:       v = MOD - 1;
      2:       v = 1;
      default: v = int'($urandom_range(0, MOD - 1));
    endcase
    set_req(i, c, v);
  endtask

  logic [NREQ-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    reset_n      = 1'b0;
    req          = '0;
    cmd          = '0;
    load_val     = '0;
    autocount_en = 1'b0;
    pause        = 1'b0;

    // reset with all requesters active, then round-robin order
    @(negedge sys_clk);
    req = '1;
    cmd = {NREQ{2'b01}};
    cyc();
    cyc();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    reset_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cyc();
      chk("rr_order", 32'(gnt), 32'(rr_exp[n]));
    end
    chk("rr_count", 32'(count), 32'd5);

    // INC wrap from FF with a single held requester
    do_reset(1);
    issue(0, 3, 8'hFF);
    chk("load_ff", 32'(count), 32'hFF);
    cyc();
    set_req(0, 1, 0);
    cyc();
    chk("inc_wrap_gnt", 32'(gnt), 32'd1);
    chk("inc_wrap_count", 32'(count), 32'h00);
    chk("inc_wrap_wrap", 32'(wrap_pulse), 32'd1);
    chk("inc_wrap_zero", 32'(zero_pulse), 32'd1);
    cyc();
    chk("inc_mask_gnt", 32'(gnt), 32'd0);
    chk("inc_mask_count", 32'(count), 32'h00);
    cyc();
    chk("inc2_gnt", 32'(gnt), 32'd1);
    chk("inc2_count", 32'(count), 32'h01);
    chk("inc2_wrap", 32'(wrap_pulse), 32'd0);
    chk("inc2_zero", 32'(zero_pulse), 32'd0);
    req = '0;

    // CLR to 0, DEC wrap to FF, LOAD 0 pulses zero only
    issue(1, 0, 0);
    chk("clr_count", 32'(count), 32'h00);
    chk("clr_zero", 32'(zero_pulse), 32'd1);
    issue(1, 2, 0);
    chk("dec_count", 32'(count), 32'hFF);
    chk("dec_wrap", 32'(wrap_pulse), 32'd1);
    chk("dec_zero", 32'(zero_pulse), 32'd0);
    issue(2, 3, 0);
    chk("load0_count", 32'(count), 32'h00);
    chk("load0_zero", 32'(zero_pulse), 32'd1);
    chk("load0_wrap", 32'(wrap_pulse), 32'd0);

    // prescaler ticks deferred behind busy requesters, overrun, then idle service
    autocount_en = 1'b1;
    do_reset(1);
    set_req(0, 1, 0);
    set_req(1, 1, 0);
    repeat (8) cyc();
    chk("tick_busy_count", 32'(count), 32'd8);
    chk("tick_overrun", 32'(overrun_pulse), 32'd1);
    req = '0;
    cyc();
    chk("tick_serve_count", 32'(count), 32'd9);
    chk("tick_serve_gnt", 32'(gnt), 32'd0);
    autocount_en = 1'b0;

    // pause freezes grants and count
    pause = 1'b1;
    set_req(2, 1, 0);
    for (int n = 0; n < 10; n++) begin
      cyc();
      chk("pause_gnt", 32'(gnt), 32'd0);
      chk("pause_count", 32'(count), 32'd9);
    end
    pause = 1'b0;
    cyc();
    chk("unpause_gnt", 32'(gnt), 32'b0100);
    chk("unpause_count", 32'(count), 32'd10);
    req = '0;

    // reset wins over a grantable INC
    set_req(0, 1, 0);
    reset_n = 1'b0;
    cyc();
    chk("rst_inc_count", 32'(count), 32'd0);
    chk("rst_inc_gnt", 32'(gnt), 32'd0);
    reset_n = 1'b1;
    req     = '0;
    cyc();
    chk("post_rst_zero", 32'(zero_pulse), 32'd0);
    chk("post_rst_wrap", 32'(wrap_pulse), 32'd0);
    chk("post_rst_ovr", 32'(overrun_pulse), 32'd0);
    chk("post_rst_gnt", 32'(gnt), 32'd0);

    // randomized traffic obeying the hold-until-granted protocol
    autocount_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        req     = '0;
      end else begin
        reset_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
          if (req[i]) begin
            if (gnt[i]) begin
              if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
              else rand_cmd(i);
            end
          end else if ($urandom_range(0, 3) == 0) begin
            rand_cmd(i);
          end
        end
      end
      pause = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 31) == 0) autocount_en = ~autocount_en;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
